// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between core writeback (A, always wins) and a
// long-latency unit (B, queued in a 2-entry FIFO), plus a busy-register scoreboard.
// Optional operand bypass from the FIFO is enabled by defining RFARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_a_we,
  input  logic [4:0]   i_a_rd,
  input  logic [N-1:0] i_a_wdata,
  input  logic         i_b_valid,
  input  logic [4:0]   i_b_rd,
  input  logic [N-1:0] i_b_wdata,
  output logic         o_b_ready,
  input  logic         i_iss_valid,
  input  logic [4:0]   i_iss_rd,
  input  logic         i_dec_valid,
  input  logic [4:0]   i_dec_rs1,
  input  logic [4:0]   i_dec_rs2,
  input  logic [4:0]   i_dec_rd,
  output logic         o_stall,
  output logic         o_fwd1_en,
  output logic         o_fwd2_en,
  output logic [N-1:0] o_fwd1_data,
  output logic [N-1:0] o_fwd2_data,
  output logic         o_rf_we,
  output logic [4:0]   o_rf_rd,
  output logic [N-1:0] o_rf_wdata,
  output logic [1:0]   o_dbg_count,
  output logic [31:0]  o_dbg_busy
);

  // B handshake: a result transfers on a posedge where i_b_valid && o_b_ready;
  // the B unit must hold rd/data stable while valid is high and ready is low.
  logic [1:0]   r_count;
  logic         r_wptr;
  logic         r_rptr;
  logic [4:0]   r_rd   [2];
  logic [N-1:0] r_data [2];
  logic [31:0]  r_busy;

  logic         w_a_eff;
  logic         w_drain;
  logic         w_push;
  logic         w_newer;
  logic [31:0]  w_busy_next;

  assign w_a_eff   = i_a_we && (i_a_rd != 5'd0);
  assign w_drain   = !w_a_eff && (r_count != 2'd0);
  assign o_b_ready = (r_count != 2'd2);
  // rd=0 results complete the handshake but are dropped here.
  assign w_push    = i_b_valid && o_b_ready && (i_b_rd != 5'd0);
  assign w_newer   = (r_count == 2'd2) ? ~r_rptr : r_rptr;

  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_rd    = 5'd0;
    o_rf_wdata = '0;
    if (w_a_eff) begin
      o_rf_we    = 1'b1;
      o_rf_rd    = i_a_rd;
      o_rf_wdata = i_a_wdata;
    end else if (w_drain) begin
      o_rf_we    = 1'b1;
      o_rf_rd    = r_rd[r_rptr];
      o_rf_wdata = r_data[r_rptr];
    end
  end

  // Issue is applied after the drain clear so a same-cycle set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_drain) w_busy_next[r_rd[r_rptr]] = 1'b0;
    if (i_iss_valid && (i_iss_rd != 5'd0)) w_busy_next[i_iss_rd] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count   <= 2'd0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_rd[0]   <= 5'd0;
      r_rd[1]   <= 5'd0;
      r_data[0] <= '0;
      r_data[1] <= '0;
      r_busy    <= 32'd0;
    end else begin
      r_busy <= w_busy_next;
      if (w_push) begin
        r_rd[r_wptr]   <= i_b_rd;
        r_data[r_wptr] <= i_b_wdata;
        r_wptr         <= ~r_wptr;
      end
      if (w_drain) r_rptr <= ~r_rptr;
      if (w_push && !w_drain)      r_count <= r_count + 2'd1;
      else if (!w_push && w_drain) r_count <= r_count - 2'd1;
    end
  end

`ifdef RFARB_BYPASS_EN
  // Newer entry is checked first so the youngest pending value is forwarded.
  always_comb begin
    o_fwd1_en   = 1'b0;
    o_fwd1_data = '0;
    o_fwd2_en   = 1'b0;
    o_fwd2_data = '0;
    if (i_dec_rs1 != 5'd0 && r_count != 2'd0) begin
      if (r_rd[w_newer] == i_dec_rs1) begin
        o_fwd1_en   = 1'b1;
        o_fwd1_data = r_data[w_newer];
      end else if (r_rd[r_rptr] == i_dec_rs1) begin
        o_fwd1_en   = 1'b1;
        o_fwd1_data = r_data[r_rptr];
      end
    end
    if (i_dec_rs2 != 5'd0 && r_count != 2'd0) begin
      if (r_rd[w_newer] == i_dec_rs2) begin
        o_fwd2_en   = 1'b1;
        o_fwd2_data = r_data[w_newer];
      end else if (r_rd[r_rptr] == i_dec_rs2) begin
        o_fwd2_en   = 1'b1;
        o_fwd2_data = r_data[r_rptr];
      end
    end
  end

  assign o_stall = i_dec_valid && ((r_busy[i_dec_rs1] && !o_fwd1_en) ||
                                   (r_busy[i_dec_rs2] && !o_fwd2_en) ||
                                   r_busy[i_dec_rd]);
`else
  logic w_unused_newer;
  assign w_unused_newer = w_newer;
  assign o_fwd1_en      = 1'b0;
  assign o_fwd2_en      = 1'b0;
  assign o_fwd1_data    = '0;
  assign o_fwd2_data    = '0;
  assign o_stall = i_dec_valid && (r_busy[i_dec_rs1] || r_busy[i_dec_rs2] || r_busy[i_dec_rd]);
`endif

  assign o_dbg_count = r_count;
  assign o_dbg_busy  = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: write-port arbitration, FIFO back-pressure,
// scoreboard set/clear priority, rd=0 handling and the optional bypass.
module tb_regfile_write_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_a_we;
  logic [4:0]  i_a_rd;
  logic [31:0] i_a_wdata;
  logic        i_b_valid;
  logic [4:0]  i_b_rd;
  logic [31:0] i_b_wdata;
  logic        o_b_ready;
  logic        i_iss_valid;
  logic [4:0]  i_iss_rd;
  logic        i_dec_valid;
  logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic        o_stall, o_fwd1_en, o_fwd2_en;
  logic [31:0] o_fwd1_data, o_fwd2_data;
  logic        o_rf_we;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_wdata;
  logic [1:0]  o_dbg_count;
  logic [31:0] o_dbg_busy;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_write_arbiter #(.N(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_we(i_a_we), .i_a_rd(i_a_rd), .i_a_wdata(i_a_wdata),
    .i_b_valid(i_b_valid), .i_b_rd(i_b_rd), .i_b_wdata(i_b_wdata), .o_b_ready(o_b_ready),
    .i_iss_valid(i_iss_valid), .i_iss_rd(i_iss_rd),
    .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
    .o_stall(o_stall), .o_fwd1_en(o_fwd1_en), .o_fwd2_en(o_fwd2_en),
    .o_fwd1_data(o_fwd1_data), .o_fwd2_data(o_fwd2_data),
    .o_rf_we(o_rf_we), .o_rf_rd(o_rf_rd), .o_rf_wdata(o_rf_wdata),
    .o_dbg_count(o_dbg_count), .o_dbg_busy(o_dbg_busy)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_a_we = 0; i_a_rd = 0; i_a_wdata = 0;
    i_b_valid = 0; i_b_rd = 0; i_b_wdata = 0;
    i_iss_valid = 0; i_iss_rd = 0;
    i_dec_valid = 0; i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_rd = 0;
  endtask

  task automatic drive_a(input logic we, input logic [4:0] rd, input logic [31:0] d);
    i_a_we = we; i_a_rd = rd; i_a_wdata = d;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
    i_b_valid = v; i_b_rd = rd; i_b_wdata = d;
  endtask

  task automatic drive_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd);
    i_dec_valid = v; i_dec_rs1 = rs1; i_dec_rs2 = rs2; i_dec_rd = rd;
  endtask

  initial begin
    idle_inputs();
    i_rst = 1'b1;
    #2;
    check("rst_b_ready", 32'(o_b_ready), 32'd1);
    check("rst_rf_we",   32'(o_rf_we),   32'd0);
    check("rst_rf_wdata", o_rf_wdata,    32'd0);
    check("rst_stall",   32'(o_stall),   32'd0);
    check("rst_fwd_en",  32'({o_fwd1_en, o_fwd2_en}), 32'd0);
    check("rst_count",   32'(o_dbg_count), 32'd0);
    check("rst_busy",    o_dbg_busy,     32'd0);
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // issue to x5, decode reading x5 must stall
    i_iss_valid = 1; i_iss_rd = 5;
    tick();
    i_iss_valid = 0;
    drive_dec(1, 5, 0, 0);
    #1;
    check("iss5_stall", 32'(o_stall), 32'd1);
    check("iss5_no_we", 32'(o_rf_we), 32'd0);
    check("iss5_busy",  o_dbg_busy, 32'h0000_0020);

    // B result for x5 pushed, drained the next cycle
    drive_b(1, 5, 32'hDEADBEEF);
    #1;
    check("b5_ready", 32'(o_b_ready), 32'd1);
    check("b5_no_same_cycle_we", 32'(o_rf_we), 32'd0);
    tick();
    drive_b(0, 0, 0);
    #1;
    check("drain5_we",   32'(o_rf_we), 32'd1);
    check("drain5_rd",   32'(o_rf_rd), 32'd5);
    check("drain5_data", o_rf_wdata,   32'hDEADBEEF);
    check("drain5_stall_held", 32'(o_stall), 32'd1);
    tick();
    check("post5_stall", 32'(o_stall), 32'd0);
    check("post5_busy",  o_dbg_busy,   32'd0);
    check("post5_we",    32'(o_rf_we), 32'd0);
    drive_dec(0, 0, 0, 0);

    // A writes x3 continuously while B offers x7, x8, x9
    drive_a(1, 3, 32'h33);
    drive_b(1, 7, 32'h77);
    #1;
    check("a3_we",   32'(o_rf_we), 32'd1);
    check("a3_rd",   32'(o_rf_rd), 32'd3);
    check("a3_data", o_rf_wdata,   32'h33);
    tick();
    drive_b(1, 8, 32'h88);
    #1;
    check("b8_ready", 32'(o_b_ready), 32'd1);
    tick();
    drive_b(1, 9, 32'h99);
    #1;
    check("full_count", 32'(o_dbg_count), 32'd2);
    check("b9_ready",   32'(o_b_ready),   32'd0);
    tick();
    check("full_hold_count", 32'(o_dbg_count), 32'd2);
    check("full_hold_rd3",   32'(o_rf_rd),     32'd3);
    drive_b(0, 0, 0);
    drive_a(0, 0, 0);
    #1;
    check("drain7_rd",    32'(o_rf_rd), 32'd7);
    check("drain7_data",  o_rf_wdata,   32'h77);
    check("drain7_ready", 32'(o_b_ready), 32'd0);
    tick();
    check("drain8_rd",    32'(o_rf_rd), 32'd8);
    check("drain8_data",  o_rf_wdata,   32'h88);
    check("drain8_ready", 32'(o_b_ready), 32'd1);
    tick();
    check("empty_we",    32'(o_rf_we),     32'd0);
    check("empty_count", 32'(o_dbg_count), 32'd0);

    // set and clear of x6 in the same cycle: set wins
    drive_b(1, 6, 32'h66);
    tick();
    drive_b(0, 0, 0);
    i_iss_valid = 1; i_iss_rd = 6;
    #1;
    check("drain6_rd", 32'(o_rf_rd), 32'd6);
    tick();
    i_iss_valid = 0;
    drive_dec(1, 0, 6, 0);
    #1;
    check("busy6_kept",  o_dbg_busy, 32'h0000_0040);
    check("busy6_stall", 32'(o_stall), 32'd1);
    drive_b(1, 6, 32'h67);
    tick();
    drive_b(0, 0, 0);
    tick();
    check("busy6_cleared", o_dbg_busy, 32'd0);
    check("stall6_drop",   32'(o_stall), 32'd0);
    drive_dec(0, 0, 0, 0);

    // rd=0 B result is accepted and dropped; issue to x0 never marks busy
    drive_b(1, 0, 32'hFF);
    #1;
    check("b0_ready", 32'(o_b_ready), 32'd1);
    tick();
    drive_b(0, 0, 0);
    check("b0_count", 32'(o_dbg_count), 32'd0);
    check("b0_no_we", 32'(o_rf_we),     32'd0);
    i_iss_valid = 1; i_iss_rd = 0;
    tick();
    i_iss_valid = 0;
    drive_dec(1, 0, 0, 0);
    #1;
    check("x0_stall", 32'(o_stall), 32'd0);
    check("x0_busy",  o_dbg_busy,   32'd0);
    drive_dec(0, 0, 0, 0);

    // x4 pending in the FIFO while A keeps the port busy
    i_iss_valid = 1; i_iss_rd = 4;
    tick();
    i_iss_valid = 0;
    drive_a(1, 3, 32'h3333);
    drive_b(1, 4, 32'h1234);
    tick();
    drive_b(0, 0, 0);
    drive_dec(1, 0, 4, 0);
    #1;
    check("byp_a_wins", 32'(o_rf_rd), 32'd3);
`ifdef RFARB_BYPASS_EN
    check("byp_fwd2_en",   32'(o_fwd2_en), 32'd1);
    check("byp_fwd2_data", o_fwd2_data,    32'h1234);
    check("byp_stall",     32'(o_stall),   32'd0);
`else
    check("byp_fwd2_en",   32'(o_fwd2_en), 32'd0);
    check("byp_fwd2_data", o_fwd2_data,    32'd0);
    check("byp_stall",     32'(o_stall),   32'd1);
`endif
    check("byp_fwd1_en", 32'(o_fwd1_en), 32'd0);

    // asynchronous reset mid-operation discards the queued entry and busy bits
    i_rst = 1'b1;
    #1;
    check("arst_count", 32'(o_dbg_count), 32'd0);
    check("arst_busy",  o_dbg_busy,       32'd0);
    check("arst_stall", 32'(o_stall),     32'd0);
    drive_a(0, 0, 0);
    #1;
    check("arst_we", 32'(o_rf_we), 32'd0);
    tick();
    i_rst = 1'b0;
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
